// File: rtl/sprite_pixel_pipe_if.sv
// Avalon-MM register bus for the sprite pixel pipe.
// The CPU side uses the master modport; sprite_pixel_pipe uses the slave modport.
interface sprite_pixel_pipe_if;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [3:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe: a three-stage pixel pipeline sitting between vga_controller and the VGA pins.
// Stage 1 performs the sprite-window hit test and issues the RAM address. Stage 2 captures the
// palette index that the RAM returns. Stage 3 looks the index up in the palette (or uses the
// background colour) and drives RGB. HS/VS travel through the same three stages so they stay aligned.
// Optional feature macro: SPRITE_PIPE_TRANSP_EN makes palette index 0 transparent, so a hit pixel
// with index 0 shows the background colour.
module sprite_pixel_pipe #(
    parameter int SPR_W    = 60,
    parameter int SPR_H    = 60,
    parameter int SPR_BASE = 3600,
    parameter int ADDR_W   = 17
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIX_EN,
    input  logic [9:0]        DRAW_X,
    input  logic [9:0]        DRAW_Y,
    input  logic              BLANK,
    input  logic              HS_IN,
    input  logic              VS_IN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [2:0]        RAM_DATA,
    sprite_pixel_pipe_if.slave avl,
    output logic [3:0]        RED,
    output logic [3:0]        GREEN,
    output logic [3:0]        BLUE,
    output logic              HS_OUT,
    output logic              VS_OUT
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(SPR_BASE);
    localparam logic [10:0]       W11       = 11'(SPR_W);
    localparam logic [10:0]       H11       = 11'(SPR_H);

    // Power-up palette: a grey ramp followed by two warm tones.
    function automatic logic [11:0] pal_reset(input logic [2:0] n);
        case (n)
            3'd0:    pal_reset = 12'h000;
            3'd1:    pal_reset = 12'h333;
            3'd2:    pal_reset = 12'h666;
            3'd3:    pal_reset = 12'h999;
            3'd4:    pal_reset = 12'hccc;
            3'd5:    pal_reset = 12'hfff;
            3'd6:    pal_reset = 12'h742;
            3'd7:    pal_reset = 12'hfa9;
            default: pal_reset = 12'h000;
        endcase
    endfunction

    logic [11:0]       palette_q [8];
    logic [11:0]       palette_d [8];
    logic [9:0]        org_x_q, org_x_d, org_y_q, org_y_d;
    logic [9:0]        shd_x_q, shd_x_d, shd_y_q, shd_y_d;
    logic [11:0]       bkg_q, bkg_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              vs_prev_q, vs_prev_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              s1_hit_q, s1_hit_d, s1_blank_q, s1_blank_d;
    logic              s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic              s2_hit_q, s2_hit_d, s2_blank_q, s2_blank_d;
    logic              s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
    logic [2:0]        s2_idx_q, s2_idx_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hs_out_q, hs_out_d, vs_out_q, vs_out_d;

    logic [10:0]       px_s, py_s, ox_s, oy_s, dx_s, dy_s;
    logic              hit_s;
    logic [ADDR_W-1:0] spr_addr_s;
    logic [31:0]       rd_s;
    logic [11:0]       lut_s;
    logic              vs_fall_s;

    // Window hit test in 11 bits so a window running past the raster edge clips instead of wrapping.
    always_comb begin
        px_s       = {1'b0, DRAW_X};
        py_s       = {1'b0, DRAW_Y};
        ox_s       = {1'b0, org_x_q};
        oy_s       = {1'b0, org_y_q};
        dx_s       = px_s - ox_s;
        dy_s       = py_s - oy_s;
        hit_s      = BLANK && (px_s >= ox_s) && (px_s < ox_s + W11)
                           && (py_s >= oy_s) && (py_s < oy_s + H11);
        spr_addr_s = BASE_ADDR + ADDR_W'(dy_s) * ADDR_W'(SPR_W) + ADDR_W'(dx_s);
    end

    // Register read mux; a read of ORG_X/ORG_Y returns the value the CPU last wrote (the shadow).
    always_comb begin
        rd_s = 32'd0;
        case (avl.AVL_ADDR)
            4'd8:    rd_s = {22'd0, shd_x_q};
            4'd9:    rd_s = {22'd0, shd_y_q};
            4'd10:   rd_s = {20'd0, bkg_q};
            default: begin
                if (!avl.AVL_ADDR[3]) begin
                    rd_s = {20'd0, palette_q[avl.AVL_ADDR[2:0]]};
                end else begin
                    rd_s = 32'd0;
                end
            end
        endcase
    end

    // Stage-3 colour selection from the registered stage-2 flags and index.
    always_comb begin
        lut_s = 12'h000;
        if (!s2_blank_q) begin
            lut_s = 12'h000;
`ifdef SPRITE_PIPE_TRANSP_EN
        end else if (s2_hit_q && (s2_idx_q != 3'd0)) begin
`else
        end else if (s2_hit_q) begin
`endif
            lut_s = palette_q[s2_idx_q];
        end else begin
            lut_s = bkg_q;
        end
    end

    // Next-state logic: register writes, origin commit at frame start, and the three pixel stages.
    always_comb begin
        palette_d  = palette_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        shd_x_d    = shd_x_q;
        shd_y_d    = shd_y_q;
        bkg_d      = bkg_q;
        rdata_d    = rdata_q;
        vs_prev_d  = vs_prev_q;
        ram_addr_d = ram_addr_q;
        s1_hit_d   = s1_hit_q;
        s1_blank_d = s1_blank_q;
        s1_hs_d    = s1_hs_q;
        s1_vs_d    = s1_vs_q;
        s2_hit_d   = s2_hit_q;
        s2_blank_d = s2_blank_q;
        s2_hs_d    = s2_hs_q;
        s2_vs_d    = s2_vs_q;
        s2_idx_d   = s2_idx_q;
        rgb_d      = rgb_q;
        hs_out_d   = hs_out_q;
        vs_out_d   = vs_out_q;
        vs_fall_s  = PIX_EN && vs_prev_q && !VS_IN;

        if (avl.AVL_CS && avl.AVL_WRITE) begin
            case (avl.AVL_ADDR)
                4'd8:    shd_x_d = avl.AVL_WRITEDATA[9:0];
                4'd9:    shd_y_d = avl.AVL_WRITEDATA[9:0];
                4'd10:   bkg_d   = avl.AVL_WRITEDATA[11:0];
                default: begin
                    if (!avl.AVL_ADDR[3]) begin
                        palette_d[avl.AVL_ADDR[2:0]] = avl.AVL_WRITEDATA[11:0];
                    end else begin
                        palette_d = palette_q;
                    end
                end
            endcase
        end else begin
            shd_x_d = shd_x_q;
        end

        if (avl.AVL_CS && avl.AVL_READ) begin
            rdata_d = rd_s;
        end else begin
            rdata_d = rdata_q;
        end

        // The commit takes the shadow as it stood before this CLK, so a same-CLK write waits a frame.
        if (vs_fall_s) begin
            org_x_d = shd_x_q;
            org_y_d = shd_y_q;
        end else begin
            org_x_d = org_x_q;
        end

        if (PIX_EN) begin
            vs_prev_d  = VS_IN;
            ram_addr_d = hit_s ? spr_addr_s : BASE_ADDR;
            s1_hit_d   = hit_s;
            s1_blank_d = BLANK;
            s1_hs_d    = HS_IN;
            s1_vs_d    = VS_IN;
            s2_idx_d   = RAM_DATA;
            s2_hit_d   = s1_hit_q;
            s2_blank_d = s1_blank_q;
            s2_hs_d    = s1_hs_q;
            s2_vs_d    = s1_vs_q;
            rgb_d      = lut_s;
            hs_out_d   = s2_hs_q;
            vs_out_d   = s2_vs_q;
        end else begin
            vs_prev_d  = vs_prev_q;
        end
    end

    // State registers; reset leaves syncs idle-high and the colour path black.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                palette_q[i] <= pal_reset(3'(i));
            end
            org_x_q    <= 10'd0;
            org_y_q    <= 10'd0;
            shd_x_q    <= 10'd0;
            shd_y_q    <= 10'd0;
            bkg_q      <= 12'h000;
            rdata_q    <= 32'd0;
            vs_prev_q  <= 1'b1;
            ram_addr_q <= BASE_ADDR;
            s1_hit_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s2_hit_q   <= 1'b0;
            s2_blank_q <= 1'b0;
            s2_hs_q    <= 1'b1;
            s2_vs_q    <= 1'b1;
            s2_idx_q   <= 3'd0;
            rgb_q      <= 12'h000;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
        end else begin
            palette_q  <= palette_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            shd_x_q    <= shd_x_d;
            shd_y_q    <= shd_y_d;
            bkg_q      <= bkg_d;
            rdata_q    <= rdata_d;
            vs_prev_q  <= vs_prev_d;
            ram_addr_q <= ram_addr_d;
            s1_hit_q   <= s1_hit_d;
            s1_blank_q <= s1_blank_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s2_hit_q   <= s2_hit_d;
            s2_blank_q <= s2_blank_d;
            s2_hs_q    <= s2_hs_d;
            s2_vs_q    <= s2_vs_d;
            s2_idx_q   <= s2_idx_d;
            rgb_q      <= rgb_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
        end
    end

    assign RAM_ADDR         = ram_addr_q;
    assign RED              = rgb_q[11:8];
    assign GREEN            = rgb_q[7:4];
    assign BLUE             = rgb_q[3:0];
    assign HS_OUT           = hs_out_q;
    assign VS_OUT           = vs_out_q;
    assign avl.AVL_READDATA = rdata_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Bench for sprite_pixel_pipe: directed vector table, hand sequences for the multi-cycle corners,
// and a randomized phase, all checked against a frame-level reference model of the pixel path.
module tb_sprite_pixel_pipe;
    localparam int SPR_W    = 60;
    localparam int SPR_H    = 60;
    localparam int SPR_BASE = 3600;
    localparam int ADDR_W   = 17;

    logic              CLK = 1'b0;
    logic              RESET, PIX_EN, BLANK, HS_IN, VS_IN;
    logic [9:0]        DRAW_X, DRAW_Y;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [2:0]        RAM_DATA = 3'd0;
    logic [3:0]        RED, GREEN, BLUE;
    logic              HS_OUT, VS_OUT;

    sprite_pixel_pipe_if avl_if ();

    sprite_pixel_pipe #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SPR_BASE(SPR_BASE), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
        .BLANK(BLANK), .HS_IN(HS_IN), .VS_IN(VS_IN), .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA),
        .avl(avl_if), .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .HS_OUT(HS_OUT), .VS_OUT(VS_OUT)
    );

    always #5 CLK = ~CLK;

    // Sprite RAM: one-CLK read latency, zero outside the sprite image.
    logic [2:0] mem [SPR_W*SPR_H];
    always @(posedge CLK) begin
        if (int'(RAM_ADDR) >= SPR_BASE && int'(RAM_ADDR) < SPR_BASE + SPR_W*SPR_H)
            RAM_DATA <= mem[int'(RAM_ADDR) - SPR_BASE];
        else
            RAM_DATA <= 3'd0;
    end

    // Reference model: register file plus a queue of pixels in flight.
    typedef struct { bit hit; int idx; bit blank; bit hs; bit vs; } pix_t;
    pix_t q[$];
    int   m_pal [8];
    int   m_bkg, m_ox, m_oy, m_sx, m_sy;
    bit   m_vs_prev;
    bit   rand_idle = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        pix_t r;
        r = '{hit: 1'b0, idx: 0, blank: 1'b0, hs: 1'b1, vs: 1'b1};
        m_pal = '{'h000, 'h333, 'h666, 'h999, 'hccc, 'hfff, 'h742, 'hfa9};
        m_bkg = 0; m_ox = 0; m_oy = 0; m_sx = 0; m_sy = 0;
        m_vs_prev = 1'b1;
        q.delete();
        q.push_back(r);
        q.push_back(r);
    endfunction

    function automatic void model_write(input int a, input int d);
        if (a < 8)        m_pal[a] = d & 'hfff;
        else if (a == 8)  m_sx = d & 'h3ff;
        else if (a == 9)  m_sy = d & 'h3ff;
        else if (a == 10) m_bkg = d & 'hfff;
    endfunction

    function automatic int model_read(input int a);
        if (a < 8)        return m_pal[a];
        else if (a == 10) return m_bkg;
        else              return 0;
    endfunction

    function automatic int colour(input pix_t p);
        if (!p.blank) return 0;
`ifdef SPRITE_PIPE_TRANSP_EN
        if (p.hit && p.idx != 0) return m_pal[p.idx];
`else
        if (p.hit) return m_pal[p.idx];
`endif
        return m_bkg;
    endfunction

    function automatic int rgb();
        return int'({RED, GREEN, BLUE});
    endfunction

    // One pixel strobe, optionally with a register write in the same CLK, then idle clock(s)
    // with scrambled inputs during which every output must hold.
    task automatic strobe(input int x, input int y, input bit b, input bit hs, input bit vs,
                          input bit wr = 1'b0, input int wa = 0, input int wd = 0);
        pix_t p, o;
        int   exp_addr, exp_rgb, n_idle;
        DRAW_X = 10'(x); DRAW_Y = 10'(y); BLANK = b; HS_IN = hs; VS_IN = vs; PIX_EN = 1'b1;
        if (wr) begin
            avl_if.AVL_CS = 1'b1; avl_if.AVL_WRITE = 1'b1;
            avl_if.AVL_ADDR = 4'(wa); avl_if.AVL_WRITEDATA = wd;
        end
        p.hit   = b && x >= m_ox && x < m_ox + SPR_W && y >= m_oy && y < m_oy + SPR_H;
        p.idx   = p.hit ? int'(mem[(y - m_oy)*SPR_W + (x - m_ox)]) : 0;
        p.blank = b; p.hs = hs; p.vs = vs;
        exp_addr = p.hit ? SPR_BASE + (y - m_oy)*SPR_W + (x - m_ox) : SPR_BASE;
        q.push_back(p);
        o = q.pop_front();
        exp_rgb = colour(o);
        if (m_vs_prev && !vs) begin m_ox = m_sx; m_oy = m_sy; end
        m_vs_prev = vs;
        if (wr) model_write(wa, wd);
        @(negedge CLK);
        PIX_EN = 1'b0; avl_if.AVL_CS = 1'b0; avl_if.AVL_WRITE = 1'b0;
        chk("ram_addr", int'(RAM_ADDR), exp_addr);
        chk("rgb", rgb(), exp_rgb);
        chk("hs_out", int'(HS_OUT), int'(o.hs));
        chk("vs_out", int'(VS_OUT), int'(o.vs));
        n_idle = rand_idle ? $urandom_range(1, 3) : 1;
        repeat (n_idle) begin
            DRAW_X = 10'($urandom); DRAW_Y = 10'($urandom);
            BLANK = 1'($urandom); HS_IN = 1'($urandom); VS_IN = 1'($urandom);
            @(negedge CLK);
        end
        chk("hold", int'({RAM_ADDR, RED, GREEN, BLUE, HS_OUT, VS_OUT}),
            int'({17'(exp_addr), 12'(exp_rgb), o.hs, o.vs}));
    endtask

    task automatic pad();
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic avl_write(input int a, input int d);
        avl_if.AVL_CS = 1'b1; avl_if.AVL_WRITE = 1'b1;
        avl_if.AVL_ADDR = 4'(a); avl_if.AVL_WRITEDATA = d;
        @(negedge CLK);
        avl_if.AVL_CS = 1'b0; avl_if.AVL_WRITE = 1'b0;
        model_write(a, d);
    endtask

    task automatic avl_read(input int a, output int d);
        avl_if.AVL_CS = 1'b1; avl_if.AVL_READ = 1'b1; avl_if.AVL_ADDR = 4'(a);
        @(negedge CLK);
        avl_if.AVL_CS = 1'b0; avl_if.AVL_READ = 1'b0;
        d = int'(avl_if.AVL_READDATA);
    endtask

    task automatic do_reset();
        RESET = 1'b1; PIX_EN = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        chk("rst_rgb", rgb(), 0);
        chk("rst_syncs", int'({HS_OUT, VS_OUT}), 3);
        chk("rst_addr", int'(RAM_ADDR), SPR_BASE);
        chk("rst_rdata", int'(avl_if.AVL_READDATA), 0);
    endtask

    // Frame boundary: VS_IN pulses low, committing the origin shadows.
    task automatic vsync_pulse();
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        strobe(0, 0, 1'b0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    typedef struct { int bkg; int x; int y; bit b; int exp_addr; int exp_rgb; } vec_t;
    vec_t tbl [9];

    initial begin
        int rd, a, d, x, y;
        tbl[0] = '{0,     0,  0, 1'b1, 3600, 'hfff};
        tbl[1] = '{0,    59, 59, 1'b1, 7199, 'hfa9};
        tbl[2] = '{0,    60,  0, 1'b1, 3600, 'h000};
        tbl[3] = '{0,     0, 60, 1'b1, 3600, 'h000};
        tbl[4] = '{0,    30,  1, 1'b1, 3690, 'h666};
        tbl[5] = '{'h00f, 60,  0, 1'b1, 3600, 'h00f};
        tbl[6] = '{'h00f,  0, 60, 1'b1, 3600, 'h00f};
        tbl[7] = '{'h00f,  0,  0, 1'b1, 3600, 'hfff};
        tbl[8] = '{'h00f, 10, 10, 1'b0, 3600, 'h000};

        for (int i = 0; i < SPR_W*SPR_H; i++) mem[i] = 3'd0;
        mem[0] = 3'd5; mem[3599] = 3'd7; mem[90] = 3'd2; mem[1] = 3'd2;
        PIX_EN = 1'b0; DRAW_X = 10'd0; DRAW_Y = 10'd0; BLANK = 1'b0; HS_IN = 1'b1; VS_IN = 1'b1;
        avl_if.AVL_CS = 1'b0; avl_if.AVL_READ = 1'b0; avl_if.AVL_WRITE = 1'b0;
        avl_if.AVL_ADDR = 4'd0; avl_if.AVL_WRITEDATA = 32'd0;
        RESET = 1'b1;
        @(negedge CLK);
        do_reset();

        // Idle strobes after reset, then the palette reset value.
        repeat (3) pad();
        chk("idle_rgb", rgb(), 0);
        avl_read(5, rd);
        chk("rd_pal5", rd, 'hfff);

        // Directed vectors, origin (0,0).
        for (int i = 0; i < 9; i++) begin
            avl_write(10, tbl[i].bkg);
            strobe(tbl[i].x, tbl[i].y, tbl[i].b, 1'b1, 1'b1);
            chk($sformatf("tbl%0d_addr", i), int'(RAM_ADDR), tbl[i].exp_addr);
            pad(); pad();
            chk($sformatf("tbl%0d_rgb", i), rgb(), tbl[i].exp_rgb);
        end

        // ORG_X written mid-frame stays pending until VS_IN falls.
        avl_write(8, 100);
        strobe(100, 0, 1'b1, 1'b1, 1'b1);
        chk("org_pend_addr", int'(RAM_ADDR), 3600);
        pad(); pad();
        chk("org_pend_rgb", rgb(), 'h00f);
        // Frame edge with an ORG_Y write in the commit CLK: that write must wait a frame.
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        strobe(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 9, 5);
        strobe(0, 0, 1'b0, 1'b1, 1'b0);
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        strobe(100, 0, 1'b1, 1'b1, 1'b1);
        chk("org_commit_addr", int'(RAM_ADDR), 3600);
        pad(); pad();
        chk("org_commit_rgb", rgb(), 'hfff);
        vsync_pulse();
        strobe(100, 0, 1'b1, 1'b1, 1'b1);
        pad(); pad();
        chk("orgy_miss_rgb", rgb(), 'h00f);
        strobe(101, 5, 1'b1, 1'b1, 1'b1);
        chk("orgy_hit_addr", int'(RAM_ADDR), 3601);

        // Palette write lands; a write in the same CLK as the lookup uses the old value.
        avl_write(2, 'habc);
        strobe(101, 5, 1'b1, 1'b1, 1'b1);
        pad();
        strobe(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 'h111);
        chk("pal_old_rgb", rgb(), 'habc);
        strobe(101, 5, 1'b1, 1'b1, 1'b1);
        pad(); pad();
        chk("pal_new_rgb", rgb(), 'h111);

        // Sync pulse shows up three strobes later.
        strobe(0, 0, 1'b0, 1'b0, 1'b1);
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        chk("hs_early", int'(HS_OUT), 1);
        strobe(0, 0, 1'b0, 1'b1, 1'b0);
        chk("hs_delayed", int'(HS_OUT), 0);
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        chk("hs_after", int'(HS_OUT), 1);
        pad();
        chk("vs_delayed", int'(VS_OUT), 0);

        // Index 0 on a hit.
        avl_write(0, 'h123);
        avl_write(10, 'h456);
        strobe(102, 5, 1'b1, 1'b1, 1'b1);
        pad(); pad();
`ifdef SPRITE_PIPE_TRANSP_EN
        chk("idx0_rgb", rgb(), 'h456);
`else
        chk("idx0_rgb", rgb(), 'h123);
`endif

        // Reset in the middle of a run of hits.
        strobe(0, 0, 1'b1, 1'b1, 1'b1);
        strobe(101, 5, 1'b1, 1'b0, 1'b1);
        do_reset();
        strobe(0, 0, 1'b1, 1'b1, 1'b1);
        strobe(0, 0, 1'b1, 1'b1, 1'b1);
        chk("post_rst_black", rgb(), 0);
        strobe(0, 0, 1'b1, 1'b1, 1'b1);
        chk("post_rst_first", rgb(), 'hfff);

        // Randomized phase.
        for (int i = 0; i < SPR_W*SPR_H; i++) mem[i] = 3'($urandom);
        rand_idle = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom_range(0, 99);
            if (a < 5) begin
                d = int'($urandom);
                avl_write($urandom_range(0, 15), d);
            end else if (a < 9) begin
                a = $urandom_range(0, 13);
                if (a >= 8) a = a + 2;
                avl_read(a, rd);
                chk($sformatf("rand_rd%0d", a), rd, model_read(a));
            end else begin
                x = m_ox + $urandom_range(0, 70) - 5;
                y = m_oy + $urandom_range(0, 70) - 5;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                if ($urandom_range(0, 19) == 0)
                    strobe(x, y, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0),
                           1'($urandom_range(0, 14) != 0), 1'b1, $urandom_range(0, 15),
                           int'($urandom));
                else
                    strobe(x, y, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0),
                           1'($urandom_range(0, 14) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
